// File: rtl/tmds_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tmds_pkg                                                     |
// | Description : TMDS control-token constants, token decode helper and the    |
// |               word-aligner FSM state encoding.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package tmds_pkg;

  // Control tokens, written as the [9:0] word the TMDS decoder expects.
  localparam logic [9:0] c_token_00 = 10'b1101010100;
  localparam logic [9:0] c_token_01 = 10'b0010101011;
  localparam logic [9:0] c_token_10 = 10'b0101010100;
  localparam logic [9:0] c_token_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  typedef struct packed {
    logic       is_ctrl;
    logic [1:0] ctrl;
  } token_t;

  // Maps a word to {is_ctrl, c1, c0}; non-tokens decode to all zeros.
  function automatic token_t decode_token(input logic [9:0] word);
    token_t tok;
    tok = '0;
    case (word)
      c_token_00: tok = '{is_ctrl: 1'b1, ctrl: 2'b00};
      c_token_01: tok = '{is_ctrl: 1'b1, ctrl: 2'b01};
      c_token_10: tok = '{is_ctrl: 1'b1, ctrl: 2'b10};
      c_token_11: tok = '{is_ctrl: 1'b1, ctrl: 2'b11};
      default:    tok = '0;
    endcase
    return tok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_bitslip_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tmds_bitslip_shifter                                         |
// | Description : 20->10 registered barrel shifter over the current and the    |
// |               previous deserialized word, with token decode and valid.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tmds_bitslip_shifter
  import tmds_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_data,
  input  logic       i_valid,
  input  logic [3:0] i_offset,
  output logic [9:0] o_data,
  output logic       o_valid,
  output logic       o_is_ctrl,
  output logic [1:0] o_ctrl
);

  logic [9:0] r_prev;
  logic [9:0] r_data;
  logic       r_valid;
  logic       r_is_ctrl;
  logic [1:0] r_ctrl;

  logic [9:0] w_tap [10];
  logic [9:0] w_word;
  token_t     w_tok;

  // Tap s is ({i_data, r_prev} >> s)[9:0]; the older word sits in the low half.
  for (genvar s = 0; s < 10; s++) begin : g_tap
    if (s == 0) begin : g_zero
      assign w_tap[s] = r_prev;
    end else begin : g_shift
      assign w_tap[s] = {i_data[s-1:0], r_prev[9:s]};
    end
  end

  // Select the tap for the current offset; offsets above 9 never occur.
  always_comb begin
    w_word = w_tap[0];
    for (int s = 1; s < 10; s++) begin
      if (i_offset == 4'(s)) w_word = w_tap[s];
    end
  end

  assign w_tok = decode_token(w_word);

  // Register the aligned word and its decode together; hold data across gaps.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prev    <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_is_ctrl <= 1'b0;
      r_ctrl    <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_prev    <= i_data;
        r_data    <= w_word;
        r_is_ctrl <= w_tok.is_ctrl;
        r_ctrl    <= w_tok.ctrl;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_is_ctrl = r_is_ctrl;
  assign o_ctrl    = r_ctrl;

endmodule
`default_nettype wire

// File: rtl/tmds_rx_word_aligner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tmds_rx_word_aligner                                         |
// | Description : Finds the TMDS word boundary by bitslip against control      |
// |               tokens and emits aligned words with lock status.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tmds_rx_word_aligner
  import tmds_pkg::*;
#(
  parameter int LOCK_RUN       = 16,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOSS_TIMEOUT   = 4096,
  parameter int SETTLE         = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_data,
  input  logic       i_valid,
  output logic [9:0] o_data,
  output logic       o_valid,
  output logic       o_is_ctrl,
  output logic [1:0] o_ctrl,
  output logic       o_locked,
  output logic [3:0] o_offset
);

  localparam int c_run_w    = $clog2(LOCK_RUN + 1);
  localparam int c_word_w   = $clog2(SEARCH_TIMEOUT + 1);
  localparam int c_loss_w   = $clog2(LOSS_TIMEOUT + 1);
  localparam int c_settle_w = $clog2(SETTLE + 1);

  localparam logic [c_run_w-1:0]    c_run_max    = c_run_w'(LOCK_RUN);
  localparam logic [c_word_w-1:0]   c_word_max   = c_word_w'(SEARCH_TIMEOUT);
  localparam logic [c_loss_w-1:0]   c_loss_max   = c_loss_w'(LOSS_TIMEOUT);
  localparam logic [c_settle_w-1:0] c_settle_max = c_settle_w'(SETTLE);
  localparam logic [3:0]            c_last_off   = 4'd9;

  state_t                  r_state,  w_state_nxt;
  logic [3:0]              r_offset, w_offset_nxt;
  logic                    r_locked, w_locked_nxt;
  logic [c_run_w-1:0]      r_run,    w_run_nxt;
  logic [c_word_w-1:0]     r_words,  w_words_nxt;
  logic [c_loss_w-1:0]     r_loss,   w_loss_nxt;
  // Counts up from 0 after reset/slip; checking is enabled once it reaches SETTLE.
  logic [c_settle_w-1:0]   r_settle, w_settle_nxt;

  logic                    w_check;
  logic [c_run_w-1:0]      w_run_inc;
  logic [c_word_w-1:0]     w_words_inc;
  logic [c_loss_w-1:0]     w_loss_inc;

  tmds_bitslip_shifter u_shifter (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .i_offset  (r_offset),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_is_ctrl (o_is_ctrl),
    .o_ctrl    (o_ctrl)
  );

  // Only registered words outside the settle window are judged.
  assign w_check     = o_valid && (r_settle == c_settle_max);
  assign w_run_inc   = !o_is_ctrl ? '0 :
                       (r_run == c_run_max) ? r_run : r_run + 1'b1;
  assign w_words_inc = (r_words == c_word_max) ? r_words : r_words + 1'b1;
  assign w_loss_inc  = o_is_ctrl ? '0 :
                       (r_loss == c_loss_max) ? r_loss : r_loss + 1'b1;

  // Next-state and counter logic; a lock on the timeout word takes precedence.
  always_comb begin
    w_state_nxt  = r_state;
    w_offset_nxt = r_offset;
    w_locked_nxt = r_locked;
    w_run_nxt    = r_run;
    w_words_nxt  = r_words;
    w_loss_nxt   = r_loss;
    w_settle_nxt = r_settle;

    if (o_valid && (r_settle != c_settle_max)) w_settle_nxt = r_settle + 1'b1;

    case (r_state)
      SEARCH: begin
        if (w_check) begin
          w_run_nxt   = w_run_inc;
          w_words_nxt = w_words_inc;
          if (w_run_inc == c_run_max) begin
            w_state_nxt  = LOCKED;
            w_locked_nxt = 1'b1;
            w_run_nxt    = '0;
            w_words_nxt  = '0;
            w_loss_nxt   = '0;
          end else if (w_words_inc == c_word_max) begin
            w_state_nxt = SLIP;
          end
        end
      end
      SLIP: begin
        w_offset_nxt = (r_offset == c_last_off) ? 4'd0 : r_offset + 4'd1;
        w_run_nxt    = '0;
        w_words_nxt  = '0;
        w_loss_nxt   = '0;
        w_settle_nxt = '0;
        w_state_nxt  = SEARCH;
      end
      LOCKED: begin
        if (w_check) begin
          w_loss_nxt = w_loss_inc;
          if (w_loss_inc == c_loss_max) begin
            w_state_nxt  = SEARCH;
            w_locked_nxt = 1'b0;
            w_loss_nxt   = '0;
            w_run_nxt    = '0;
            w_words_nxt  = '0;
          end
        end
      end
      default: begin
        w_state_nxt = SEARCH;
      end
    endcase
  end

  // State, offset and counter registers; reset clears everything.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= SEARCH;
      r_offset <= '0;
      r_locked <= 1'b0;
      r_run    <= '0;
      r_words  <= '0;
      r_loss   <= '0;
      r_settle <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_offset <= w_offset_nxt;
      r_locked <= w_locked_nxt;
      r_run    <= w_run_nxt;
      r_words  <= w_words_nxt;
      r_loss   <= w_loss_nxt;
      r_settle <= w_settle_nxt;
    end
  end

  assign o_locked = r_locked;
  assign o_offset = r_offset;

endmodule
`default_nettype wire

// File: tb/tb_tmds_rx_word_aligner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tmds_rx_word_aligner                                      |
// | Description : Directed self-checking bench for the TMDS word aligner.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tmds_rx_word_aligner;

  localparam logic [9:0] c_tok [4] = '{10'b1101010100, 10'b0010101011,
                                       10'b0101010100, 10'b1010101011};
  // Pixel words whose every rotation contains a run of five equal bits,
  // so no bit offset can make them look like a token.
  localparam logic [9:0] c_pix  = 10'b0111110000;
  localparam logic [9:0] c_pix2 = 10'b1000001111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [9:0] data = '0;
  logic [9:0] o_data;
  logic       o_valid;
  logic       o_is_ctrl;
  logic [1:0] o_ctrl;
  logic       o_locked;
  logic [3:0] o_offset;

  int checks = 0;
  int failures = 0;
  int k;
  int base_slips;
  int base_bad;

  always #5 clk = ~clk;

  tmds_rx_word_aligner dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_data    (data),
    .i_valid   (valid),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_is_ctrl (o_is_ctrl),
    .o_ctrl    (o_ctrl),
    .o_locked  (o_locked),
    .o_offset  (o_offset)
  );

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [9:0] data;
    logic       e_valid;
    logic [9:0] e_data;
    logic       e_is_ctrl;
    logic [1:0] e_ctrl;
    logic       e_locked;
    logic [3:0] e_offset;
  } vec_t;

  vec_t vecs[$];

  // Offset monitor: every change must be a single +1 step modulo 10.
  logic       mon_en = 1'b0;
  logic [3:0] mon_prev = '0;
  int         slips = 0;
  int         slip_bad = 0;

  always @(negedge clk) begin
    if (mon_en && (o_offset != mon_prev)) begin
      slips <= slips + 1;
      if (o_offset != ((mon_prev == 4'd9) ? 4'd0 : mon_prev + 4'd1)) slip_bad <= slip_bad + 1;
    end
    mon_prev <= o_offset;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic r, input logic v, input logic [9:0] d,
                              input logic ev, input logic [9:0] ed, input logic ei,
                              input logic [1:0] ec, input logic el, input logic [3:0] eo);
    vec_t x;
    x.rst_n = r; x.valid = v; x.data = d;
    x.e_valid = ev; x.e_data = ed; x.e_is_ctrl = ei;
    x.e_ctrl = ec; x.e_locked = el; x.e_offset = eo;
    return x;
  endfunction

  // Video-like stream: 20 blanking tokens at the start of every 800-word line.
  function automatic logic [9:0] line_word(input int n);
    return ((n % 800) < 20) ? c_tok[0] : c_pix;
  endfunction

  // Same stream seen through a deserializer whose boundary is 7 bits off.
  function automatic logic [9:0] skew7(input int n);
    logic [19:0] cat;
    cat = {line_word(n), (n == 0) ? c_pix : line_word(n - 1)};
    return cat[16:7];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [9:0] d);
    rst_n = r;
    valid = v;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},   o_data,   0);
    check({tag, "_valid"},  o_valid,  0);
    check({tag, "_isctrl"}, o_is_ctrl, 0);
    check({tag, "_ctrl"},   o_ctrl,   0);
    check({tag, "_locked"}, o_locked, 0);
    check({tag, "_offset"}, o_offset, 0);
  endtask

  initial begin
    // Reset held with valid high, then an aligned mixed-token stream. At offset 0
    // the shifter emits the word received before, so the first output is the
    // cleared history word. Two settle words, then 16 tokens: the run completes on
    // the 18th output, and lock shows one clock after the 18th valid input.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b0, 1'b1, c_tok[0], 1'b0, 10'd0, 1'b0, 2'd0, 1'b0, 4'd0));
    for (int n = 1; n <= 20; n++)
      vecs.push_back(mk(1'b1, 1'b1, c_tok[(n - 1) % 4], 1'b1,
                        (n == 1) ? 10'd0 : c_tok[(n - 2) % 4], n > 1,
                        (n == 1) ? 2'd0 : 2'((n - 2) % 4), n >= 19, 4'd0));
    vecs.push_back(mk(1'b1, 1'b1, c_pix, 1'b1, c_tok[3], 1'b1, 2'd3, 1'b1, 4'd0));
    vecs.push_back(mk(1'b1, 1'b1, c_pix, 1'b1, c_pix, 1'b0, 2'd0, 1'b1, 4'd0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].valid, vecs[i].data);
      check($sformatf("vec%0d_valid", i),  o_valid,   vecs[i].e_valid);
      check($sformatf("vec%0d_data", i),   o_data,    vecs[i].e_data);
      check($sformatf("vec%0d_isctrl", i), o_is_ctrl, vecs[i].e_is_ctrl);
      check($sformatf("vec%0d_ctrl", i),   o_ctrl,    vecs[i].e_ctrl);
      check($sformatf("vec%0d_locked", i), o_locked,  vecs[i].e_locked);
      check($sformatf("vec%0d_offset", i), o_offset,  vecs[i].e_offset);
    end

    // Loss: 4095 pixel words leave the shifter, then a token in the 4096th slot.
    // Without that token lock would drop two inputs later; with it lock holds
    // until 4096 further non-ctrl outputs, i.e. it drops on the 4098th pixel input.
    for (int j = 0; j < 4093; j++) drive(1'b1, 1'b1, c_pix);
    check("loss_pre_locked", o_locked, 1);
    drive(1'b1, 1'b1, c_tok[0]);
    drive(1'b1, 1'b1, c_pix);
    drive(1'b1, 1'b1, c_pix);
    check("loss_keep_by_token", o_locked, 1);
    for (int r = 3; r <= 4097; r++) drive(1'b1, 1'b1, c_pix);
    check("loss_hold_4097", o_locked, 1);
    drive(1'b1, 1'b1, c_pix);
    check("loss_drop", o_locked, 0);
    check("loss_offset", o_offset, 0);

    // Bit offset 7: expect three single-step slips and lock at offset 3.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, c_tok[0]);
    base_slips = slips;
    base_bad   = slip_bad;
    mon_en     = 1'b1;
    k = 0;
    while (k < 12000 && !o_locked) begin
      drive(1'b1, 1'b1, skew7(k));
      k++;
    end
    check("off7_locked", o_locked, 1);
    check("off7_offset", o_offset, 3);
    check("off7_slips", slips - base_slips, 3);
    check("off7_slip_steps", slip_bad - base_bad, 0);
    for (int j = 0; j < 40; j++) begin
      drive(1'b1, 1'b1, skew7(k));
      check("off7_data", o_data, line_word(k - 1));
      check("off7_isctrl", o_is_ctrl, line_word(k - 1) == c_tok[0]);
      k++;
    end
    mon_en = 1'b0;

    // Reset while locked clears everything.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, c_tok[0]);
    check_all_zero("midlock_reset");

    // Gaps: same lock word count, o_valid follows i_valid one clock later, data held.
    for (int n = 1; n <= 20; n++) begin
      drive(1'b1, 1'b1, c_tok[0]);
      check("gap_valid_hi", o_valid, 1);
      check("gap_data_hi", o_data, (n == 1) ? 10'd0 : c_tok[0]);
      check("gap_locked_hi", o_locked, n >= 19);
      drive(1'b1, 1'b0, c_pix2);
      check("gap_valid_lo", o_valid, 0);
      check("gap_data_hold", o_data, (n == 1) ? 10'd0 : c_tok[0]);
      check("gap_locked_lo", o_locked, n >= 18);
    end

    // Wrap: force a first slip with token-free input, then an offset-0 stream
    // must walk 2..9, wrap to 0 and lock there (ten offset changes in total).
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, c_tok[0]);
    base_slips = slips;
    base_bad   = slip_bad;
    mon_en     = 1'b1;
    k = 0;
    while (k < 3000 && o_offset != 4'd1) begin
      drive(1'b1, 1'b1, c_pix);
      k++;
    end
    check("wrap_first_slip", o_offset, 1);
    k = 0;
    while (k < 25000 && !o_locked) begin
      drive(1'b1, 1'b1, line_word(k));
      k++;
    end
    check("wrap_locked", o_locked, 1);
    check("wrap_offset", o_offset, 0);
    check("wrap_slips", slips - base_slips, 10);
    check("wrap_slip_steps", slip_bad - base_bad, 0);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
